// File: rtl/aes_dec_iter.sv
// aes_dec_iter: iterative AES-128 decryption core (FIPS-197 inverse cipher).
// The key schedule is expanded on chip, then one inverse round runs per clock.
// Without the key cache, done pulses 20 edges after the start edge.
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high reset (wins over start)
//   start       request; sampled only when idle (including the done cycle)
//   ciphertext  128-bit block, byte 0 at [127:120], column-major state
//   key         128-bit cipher key, same byte order
//   plaintext   registered result; holds until the next completion or reset
//   done        one-cycle pulse; plaintext is valid in the same cycle
//   busy        high while expanding the key or running rounds
//
// Optional feature: define AES_DEC_KEY_CACHE_EN to keep the last expanded key.
// A start whose key matches it skips expansion, and done arrives 10 edges later.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after a block
// KEXP  | building rk[1..10], one round key per edge
// ROUND | inverse rounds using rk[r], r counting 9 down to 0
module aes_dec_iter (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] ciphertext,
   input  logic [127:0] key,
   output logic [127:0] plaintext,
   output logic         done,
   output logic         busy
);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   typedef enum logic [1:0] {IDLE, KEXP, ROUND} state_t;

   state_t       state;
   logic [127:0] rk [0:10];
   logic [127:0] ct_reg;
   logic [127:0] data;
   logic [3:0]   cnt;
   logic [3:0]   r;
   logic [3:0]   kidx;
   logic [127:0] rk_next;
   logic [127:0] inv_core;
   logic [127:0] round_out;
`ifdef AES_DEC_KEY_CACHE_EN
   logic         key_valid;
   logic [127:0] cached_key;
`endif

   // Tables are stored with entry 0 in the top byte, so entry x sits at 8*(255-x).
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = {~b, 3'b000};
      return SBOX[idx +: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [10:0] idx;
      idx = {~b, 3'b000};
      return INV_SBOX[idx +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] key_expand(input logic [127:0] prev, input logic [7:0] rc);
      logic [31:0] w3, t, n0, n1, n2, n3;
      w3 = prev[31:0];
      // SubWord(RotWord(w3)) xor Rcon
      t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      n0 = prev[127:96] ^ t;
      n1 = prev[95:64]  ^ n0;
      n2 = prev[63:32]  ^ n1;
      n3 = w3           ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Byte (row + 4*col) lives at [127-8*(row+4*col) -: 8]; row r rotates right by r.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int rr = 0; rr < 4; rr++) begin
            o[127-8*(rr+4*c) -: 8] = s[127-8*(rr+4*((c-rr+4)%4)) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
      end
      return o;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] m11 [4];
      logic [7:0] m13 [4];
      logic [7:0] m14 [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]   = col[31-8*i -: 8];
         x2     = xt(a[i]);
         x4     = xt(x2);
         x8     = xt(x4);
         m9[i]  = x8 ^ a[i];
         m11[i] = x8 ^ x2 ^ a[i];
         m13[i] = x8 ^ x4 ^ a[i];
         m14[i] = x8 ^ x4 ^ x2;
      end
      return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
              m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
              m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
              m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
              inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
   endfunction

   // cnt is 0 outside KEXP; clamp the index so the array read stays in range.
   assign kidx      = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
   assign rk_next   = key_expand(rk[kidx], rcon(cnt));
   assign inv_core  = inv_sub_bytes(inv_shift_rows(data)) ^ rk[r];
   assign round_out = inv_mix_columns(inv_core);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         plaintext <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         cnt       <= 4'd0;
         r         <= 4'd0;
`ifdef AES_DEC_KEY_CACHE_EN
         key_valid <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
                  if (key_valid && (key == cached_key)) begin
                     data  <= ciphertext ^ rk[10];
                     r     <= 4'd9;
                     state <= ROUND;
                  end else begin
`else
                  begin
`endif
                     ct_reg <= ciphertext;
                     rk[0]  <= key;
                     cnt    <= 4'd1;
                     state  <= KEXP;
                  end
               end
            end
            KEXP: begin
               rk[cnt] <= rk_next;
               if (cnt == 4'd10) begin
                  // rk[10] is being written this edge, so whiten with the fresh value.
                  data  <= ct_reg ^ rk_next;
                  r     <= 4'd9;
                  cnt   <= 4'd0;
                  state <= ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
                  cached_key <= rk[0];
                  key_valid  <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ROUND: begin
               if (r == 4'd0) begin
                  plaintext <= inv_core;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  data <= round_out;
                  r    <= r - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_dec_iter.sv
// Testbench for aes_dec_iter: textbook AES-128 inverse-cipher model with
// S-boxes derived from GF(2^8) arithmetic, a cycle-level latency model,
// directed FIPS-197 scenarios and a randomized phase.
module tb_aes_dec_iter;

   logic         clk = 1'b0;
   logic         reset, start;
   logic [127:0] ciphertext, key, plaintext;
   logic         done, busy;

   always #5 clk = ~clk;

   aes_dec_iter dut (
      .clk(clk), .reset(reset), .start(start), .ciphertext(ciphertext),
      .key(key), .plaintext(plaintext), .done(done), .busy(busy));

`ifdef AES_DEC_KEY_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [7:0] o;
      o = (v << n) | (v >> (8 - n));
      return o;
   endfunction

   function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [127:0] k);
      logic [7:0] w [44][4];
      logic [7:0] t [4];
      logic [7:0] st [16];
      logic [7:0] tmp [16];
      logic [7:0] rc, a0, a1, a2, a3, t0;
      logic [127:0] res;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) w[i][j] = k[127-8*(4*i+j) -: 8];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
         if (i % 4 == 0) begin
            t0   = t[0];
            t[0] = sb[t[1]] ^ rc;
            t[1] = sb[t[2]];
            t[2] = sb[t[3]];
            t[3] = sb[t0];
            rc   = gmul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
      end
      for (int i = 0; i < 16; i++) st[i] = ct[127-8*i -: 8] ^ w[40 + i/4][i%4];
      for (int rd = 9; rd >= 0; rd--) begin
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) tmp[rr+4*c] = st[rr+4*((c-rr+4)%4)];
         for (int i = 0; i < 16; i++) st[i] = isb[tmp[i]] ^ w[4*rd + i/4][i%4];
         if (rd > 0) begin
            for (int c = 0; c < 4; c++) begin
               a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
               st[4*c]   = gmul(a0,8'd14) ^ gmul(a1,8'd11) ^ gmul(a2,8'd13) ^ gmul(a3,8'd9);
               st[4*c+1] = gmul(a0,8'd9)  ^ gmul(a1,8'd14) ^ gmul(a2,8'd11) ^ gmul(a3,8'd13);
               st[4*c+2] = gmul(a0,8'd13) ^ gmul(a1,8'd9)  ^ gmul(a2,8'd14) ^ gmul(a3,8'd11);
               st[4*c+3] = gmul(a0,8'd11) ^ gmul(a1,8'd13) ^ gmul(a2,8'd9)  ^ gmul(a3,8'd14);
            end
         end
      end
      res = '0;
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
      return res;
   endfunction

   // Cycle model: a start accepted while idle completes m_rem edges later.
   int           m_rem = 0;
   bit           m_done = 1'b0;
   bit           m_kv = 1'b0;
   bit           m_hit;
   logic [127:0] m_pt = '0, m_res = '0, m_ck = '0, m_k = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_rem = 0; m_done = 1'b0; m_pt = '0; m_kv = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               m_done = 1'b1; m_pt = m_res; m_kv = 1'b1; m_ck = m_k;
            end
         end else if (start) begin
            m_res = model_dec(ciphertext, key);
            m_hit = CACHE && m_kv && (key == m_ck);
            m_k   = key;
            m_rem = m_hit ? 10 : 20;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", {127'b0, busy}, {127'b0, m_rem > 0});
         chk("done", {127'b0, done}, {127'b0, m_done});
         chk("plaintext", plaintext, m_pt);
      end
   end

   // Start one block at the current negedge; return at the negedge showing done.
   task automatic run_block(input logic [127:0] ct, input logic [127:0] k,
                            output int lat, output int bcnt, output logic [127:0] pt);
      ciphertext = ct; key = k; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ciphertext = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      lat = 0;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 60) begin
         @(negedge clk);
         lat++;
         if (busy) bcnt++;
      end
      if (!done) begin
         errors++;
         $display("FAIL timeout actual=no_done required=done");
      end
      pt = plaintext;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin : timeout_guard
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin : main
      int lat, bcnt, ndone;
      logic [127:0] pt;
      logic [127:0] pool [4];
      logic [7:0] inv, s;

      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
         s = inv ^ rotl8(inv,1) ^ rotl8(inv,2) ^ rotl8(inv,3) ^ rotl8(inv,4) ^ 8'h63;
         sb[x] = s;
         isb[s] = x[7:0];
      end

      chk("model_sbox_00", {120'b0, sb[0]}, 128'h63);
      chk("model_isbox_00", {120'b0, isb[0]}, 128'h52);
      chk("model_c1", model_dec(C1_CT, C1_KEY), C1_PT);
      chk("model_b", model_dec(B_CT, B_KEY), B_PT);

      reset = 1'b1; start = 1'b0; ciphertext = '0; key = '0;
      @(negedge clk);
      chk_en = 1'b1;
      chk("reset_pt", plaintext, '0);
      chk("reset_busy", {127'b0, busy}, '0);
      chk("reset_done", {127'b0, done}, '0);

      // start together with reset
      start = 1'b1; ciphertext = C1_CT; key = C1_KEY;
      repeat (2) @(negedge clk);
      chk("rst_start_busy", {127'b0, busy}, '0);
      chk("rst_start_done", {127'b0, done}, '0);
      chk("rst_start_pt", plaintext, '0);
      start = 1'b0; reset = 1'b0;
      @(negedge clk);

      // back-to-back: C.1, B, C.1, C.1 (last one hits the cache if enabled)
      run_block(C1_CT, C1_KEY, lat, bcnt, pt);
      chk("c1_latency", lat, 20); chk("c1_busy_cycles", bcnt, 20); chk("c1_pt", pt, C1_PT);
      run_block(B_CT, B_KEY, lat, bcnt, pt);
      chk("b_latency", lat, 20); chk("b_busy_cycles", bcnt, 20); chk("b_pt", pt, B_PT);
      run_block(C1_CT, C1_KEY, lat, bcnt, pt);
      chk("c1b_latency", lat, 20); chk("c1b_pt", pt, C1_PT);
      run_block(C1_CT, C1_KEY, lat, bcnt, pt);
      chk("c1c_latency", lat, CACHE ? 10 : 20); chk("c1c_pt", pt, C1_PT);
      @(negedge clk);

      // ignored start at E5
      do_reset();
      ciphertext = C1_CT; key = C1_KEY; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; ciphertext = B_CT; key = B_KEY;
      @(negedge clk);
      start = 1'b0;
      lat = 5;
      while (!done && lat < 60) begin @(negedge clk); lat++; end
      chk("ign_latency", lat, 20);
      chk("ign_pt", plaintext, C1_PT);
      ndone = 0;
      repeat (25) begin @(negedge clk); if (done) ndone++; end
      chk("ign_extra_done", ndone, 0);

      // reset at E12
      do_reset();
      ciphertext = C1_CT; key = C1_KEY; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_pt", plaintext, '0);
      chk("abort_busy", {127'b0, busy}, '0);
      ndone = 0;
      repeat (12) begin @(negedge clk); if (done) ndone++; end
      chk("abort_no_done", ndone, 0);
      run_block(B_CT, B_KEY, lat, bcnt, pt);
      chk("after_abort_latency", lat, 20); chk("after_abort_pt", pt, B_PT);

      // randomized phase: model checks every cycle
      pool[0] = C1_KEY; pool[1] = B_KEY;
      pool[2] = {$urandom, $urandom, $urandom, $urandom};
      pool[3] = {$urandom, $urandom, $urandom, $urandom};
      ndone = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset = ($urandom_range(0, 249) == 0);
         start = ($urandom_range(0, 3) == 0);
         ciphertext = {$urandom, $urandom, $urandom, $urandom};
         key = pool[$urandom_range(0, 3)];
         @(negedge clk);
         if (done) ndone++;
      end
      reset = 1'b0; start = 1'b0;
      checks++;
      if (ndone < 20) begin
         errors++;
         $display("FAIL random_done_count actual=%0d required=>=20", ndone);
      end
      repeat (25) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
